// File: rtl/recv_protocol.sv
// ---------------------------------------------------------------------------
// recv_protocol
//   Serial receive stage that sits directly behind the TX protocol unit.
//   It hunts S_Data for the start sequence 0,1,1,1,1,1, then shifts in one
//   sz_DATA-bit frame MSB first and presents it in parallel on RX_Data with a
//   valid/ack handshake toward the router core.  A frame that completes while
//   the previous one is still unacknowledged raises the sticky overrun flag.
//
// Parameters
//   sz_DATA  frame payload width in bits (default 55)
//   sz_ONES  consecutive 1s required after an armed 0 (default 5)
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   S_Data    in   serial line from the transmitter
//   rx_ack    in   consumer acknowledge, clears rx_valid
//   RX_Data   out  last complete frame, bit sz_DATA-1 = first bit received
//   rx_valid  out  RX_Data holds an unacknowledged frame
//   rx_busy   out  receiver is inside a start sequence or a payload
//   overrun   out  sticky: a frame completed while rx_valid was still high
//
// Build option
//   RECV_SYNC_IN_EN  when defined, S_Data passes through a 2-flop
//                    synchroniser (reset to 0) before the hunt/shift logic;
//                    every latency grows by two cycles.
// ---------------------------------------------------------------------------
module recv_protocol #(
    parameter int sz_DATA = 55,
    parameter int sz_ONES = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               S_Data,
    input  logic               rx_ack,
    output logic [sz_DATA-1:0] RX_Data,
    output logic               rx_valid,
    output logic               rx_busy,
    output logic               overrun
);

    localparam int ONES_W = $clog2(sz_ONES + 1);
    localparam int BITS_W = $clog2(sz_DATA + 1);
    localparam logic [ONES_W-1:0] ONES_LAST = ONES_W'(sz_ONES);
    localparam logic [BITS_W-1:0] BITS_FULL = BITS_W'(sz_DATA);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SEQ  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                armed;
    logic                armed_nxt;
    logic [ONES_W-1:0]   ones_cnt;
    logic [ONES_W-1:0]   ones_nxt;
    logic [BITS_W-1:0]   bit_cnt;
    logic [BITS_W-1:0]   bit_nxt;
    // Only sz_DATA-1 bits are stored: the last payload bit is taken straight
    // from the line on the completion edge, so it never needs a flop here.
    logic [sz_DATA-2:0]  shift_reg;
    logic [sz_DATA-2:0]  shift_nxt;
    logic [sz_DATA-1:0]  frame_word;
    logic                frame_done;
    logic                s_in;

`ifdef RECV_SYNC_IN_EN
    logic s_data_p0;
    logic s_data_p1;

    // Input synchroniser boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_data_p0 <= 1'b0;
            s_data_p1 <= 1'b0;
        end else begin
            s_data_p0 <= S_Data;
            s_data_p1 <= s_data_p0;
        end
    end

    assign s_in = s_data_p1;
`else
    assign s_in = S_Data;
`endif

    assign frame_word = {shift_reg, s_in};

    // State register (together with the counters that travel with it)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            armed     <= 1'b0;
            ones_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            armed     <= armed_nxt;
            ones_cnt  <= ones_nxt;
            bit_cnt   <= bit_nxt;
            shift_reg <= shift_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state;
        armed_nxt  = armed;
        ones_nxt   = ones_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_reg;
        frame_done = 1'b0;

        case (state)
            HUNT: begin
                if (!s_in) begin
                    armed_nxt = 1'b1;
                    ones_nxt  = '0;
                end else if (armed) begin
                    ones_nxt  = ONES_W'(1);
                    state_nxt = SEQ;
                end
            end

            SEQ: begin
                if (s_in) begin
                    ones_nxt = ones_cnt + ONES_W'(1);
                    if (ones_nxt == ONES_LAST) begin
                        bit_nxt   = BITS_FULL;
                        state_nxt = DATA;
                    end
                end else begin
                    // This zero re-arms, so it can start the next attempt.
                    armed_nxt = 1'b1;
                    ones_nxt  = '0;
                    state_nxt = HUNT;
                end
            end

            DATA: begin
                shift_nxt = frame_word[sz_DATA-2:0];
                bit_nxt   = bit_cnt - BITS_W'(1);
                if (bit_cnt == BITS_W'(1)) begin
                    // A fresh 0 is required before the next start sequence.
                    frame_done = 1'b1;
                    armed_nxt  = 1'b0;
                    ones_nxt   = '0;
                    state_nxt  = HUNT;
                end
            end

            default: begin
                armed_nxt = 1'b0;
                ones_nxt  = '0;
                bit_nxt   = '0;
                state_nxt = HUNT;
            end
        endcase
    end

    // Output logic
    always_comb begin
        rx_busy = 1'b0;
        if ((state == SEQ) || (state == DATA)) begin
            rx_busy = 1'b1;
        end
    end

    // Handshake toward the router core.  A completion coinciding with an
    // ack is treated as the consumer having taken the old frame in time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RX_Data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else if (frame_done) begin
            RX_Data  <= frame_word;
            rx_valid <= 1'b1;
            if (rx_valid && !rx_ack) begin
                overrun <= 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_recv_protocol.sv
// ---------------------------------------------------------------------------
// tb_recv_protocol
//   Directed scenarios followed by randomized frames, noise and acks, all
//   compared every cycle against a behavioural model that works on a window
//   of recently received line bits rather than on the receiver's states.
// ---------------------------------------------------------------------------
module tb_recv_protocol;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        S_Data = 1'b0;
    logic        rx_ack = 1'b0;
    logic [54:0] RX_Data;
    logic        rx_valid;
    logic        rx_busy;
    logic        overrun;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    recv_protocol dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .S_Data   (S_Data),
        .rx_ack   (rx_ack),
        .RX_Data  (RX_Data),
        .rx_valid (rx_valid),
        .rx_busy  (rx_busy),
        .overrun  (overrun)
    );

    // Behavioural model state
    logic [5:0]  m_win;       // last six line bits seen while hunting
    int          m_nh;        // number of bits seen since hunting began
    bit          m_in_frame;
    int          m_cnt;
    logic [54:0] m_acc;
    logic [54:0] m_rx;
    bit          m_valid;
    bit          m_ovr;
    logic [1:0]  m_dly;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_win      = '0;
        m_nh       = 0;
        m_in_frame = 0;
        m_cnt      = 0;
        m_acc      = '0;
        m_rx       = '0;
        m_valid    = 0;
        m_ovr      = 0;
        m_dly      = '0;
    endtask

    task automatic model_edge(input bit b, input bit ack);
        bit s;
        bit done;
        done = 0;
`ifdef RECV_SYNC_IN_EN
        s     = m_dly[1];
        m_dly = {m_dly[0], b};
`else
        s = b;
`endif
        if (m_in_frame) begin
            m_acc = {m_acc[53:0], s};
            m_cnt++;
            if (m_cnt == 55) begin
                done       = 1;
                m_in_frame = 0;
                m_nh       = 0;
                m_win      = '0;
            end
        end else begin
            m_win = {m_win[4:0], s};
            m_nh++;
            if (m_nh >= 6 && m_win == 6'b011111) begin
                m_in_frame = 1;
                m_cnt      = 0;
                m_acc      = '0;
            end
        end
        if (done) begin
            if (m_valid && !ack) m_ovr = 1;
            m_valid = 1;
            m_rx    = m_acc;
        end else if (ack) begin
            m_valid = 0;
        end
    endtask

    // Busy while collecting a payload, or while the hunt history ends in a
    // zero followed by one to four ones.
    function automatic bit model_busy();
        int t;
        if (m_in_frame) return 1;
        t = 0;
        while (t < 6 && t < m_nh && m_win[t]) t++;
        return (t >= 1 && t <= 4 && m_nh > t && !m_win[t]);
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, rx_valid, m_valid);
        chk({tag, "_busy"}, rx_busy, model_busy());
        chk({tag, "_ovr"}, overrun, m_ovr);
        chk({tag, "_data"}, RX_Data, m_rx);
    endtask

    task automatic step(input bit b, input bit ack);
        S_Data = b;
        rx_ack = ack;
        @(posedge clk);
        #1;
        model_edge(b, ack);
        check_outputs("cyc");
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        S_Data = 1'b0;
        rx_ack = 1'b0;
        #2;
        model_reset();
        chk("rst_data", RX_Data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_ovr", overrun, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [54:0] d, input int gap, input int nbits,
                              input bit ack_last, input int ack_pct);
        logic [5:0] sq;
        bit a;
        sq = 6'b011111;
        for (int i = 0; i < gap; i++) step(1'b0, ($urandom_range(99) < ack_pct));
        for (int i = 5; i >= 0; i--) step(sq[i], ($urandom_range(99) < ack_pct));
        for (int i = 0; i < nbits; i++) begin
            a = ($urandom_range(99) < ack_pct);
            if (ack_last && i == 54) a = 1'b1;
            step(d[54-i], a);
        end
    endtask

    task automatic flush();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        rst_n  = 1'b0;
        S_Data = 1'b0;
        rx_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_data", RX_Data, 0);
        chk("init_valid", rx_valid, 0);
        chk("init_busy", rx_busy, 0);
        chk("init_ovr", overrun, 0);
        rst_n = 1'b1;

        // Basic frame after four idle zeros
        send_frame(55'h55_5555_5555_5555, 4, 55, 1'b0, 0);
        flush();
        chk("tp1_data", RX_Data, 55'h55_5555_5555_5555);
        chk("tp1_valid", rx_valid, 1);
        chk("tp1_busy", rx_busy, 0);
        step(1'b0, 1'b1);
        chk("tp1_ack", rx_valid, 0);

        // Aborted sequence 0,1,1,1,0 followed by a good one
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        send_frame(55'h7F_FFFF_FFFF_FFFF, 0, 55, 1'b0, 0);
        flush();
        chk("tp2_data", RX_Data, 55'h7F_FFFF_FFFF_FFFF);
        chk("tp2_valid", rx_valid, 1);
        step(1'b0, 1'b1);

        // Line held high from reset: never armed
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
`ifndef RECV_SYNC_IN_EN
        chk("tp3_idle_valid", rx_valid, 0);
        chk("tp3_idle_busy", rx_busy, 0);
`endif
        send_frame(55'h1, 1, 55, 1'b0, 0);
        flush();
        chk("tp3_data", RX_Data, 55'h1);

        // Two frames without ack
        do_reset();
        send_frame(55'h0A, 2, 55, 1'b0, 0);
        send_frame(55'h0B, 2, 55, 1'b0, 0);
        flush();
        chk("tp4_data", RX_Data, 55'h0B);
        chk("tp4_valid", rx_valid, 1);
        chk("tp4_ovr", overrun, 1);

        // Same, with ack on the completion edge of the second frame
        do_reset();
        send_frame(55'h0A, 2, 55, 1'b0, 0);
        send_frame(55'h0B, 2, 55, 1'b1, 0);
        flush();
        chk("tp5_data", RX_Data, 55'h0B);
        chk("tp5_valid", rx_valid, 1);
        chk("tp5_ovr", overrun, 0);

        // Reset in the middle of a frame, then a clean frame
        do_reset();
        send_frame(55'h2A_AAAA_0000_FFFF, 2, 30, 1'b0, 0);
        do_reset();
        send_frame(55'h12_3456_789A_BCDE, 2, 55, 1'b0, 0);
        flush();
        chk("tp6_data", RX_Data, 55'h12_3456_789A_BCDE);
        chk("tp6_valid", rx_valid, 1);

        // Randomized traffic: noise, gaps, acks and occasional resets
        for (int f = 0; f < 60; f++) begin
            logic [54:0] d;
            int noise;
            if ($urandom_range(19) == 0) do_reset();
            noise = $urandom_range(8);
            for (int i = 0; i < noise; i++)
                step(($urandom_range(3) != 0), ($urandom_range(99) < 20));
            d = {$urandom, $urandom};
            send_frame(d, $urandom_range(3), 55, ($urandom_range(3) == 0), 20);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
